ifq_fetch: RTL and testbench
============================

# ifq_fetch

Instruction fetch queue (IFQ) that sits directly upstream of the dispatch unit. It owns the fetch PC and issues sequential reads to a synchronous instruction memory. Returned {pc, icode} pairs are buffered in a small circular queue, with the head presented show-ahead to dispatch. On a redirect from dispatch (jump, jalr or taken branch), the queue is flushed, any in-flight read is discarded, and fetch resumes at the redirect target.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_rd_en  out  1  read request this cycle.
- imem_addr  out  32  byte address of the request (always word-aligned).
- imem_rdata  in  32  instruction word, valid the cycle after the request (registered memory, fixed 1-cycle latency, never stalls).
- ifq_icode  out  32  instruction at queue head.
- ifq_pc  out  32  PC of the head instruction.
- ifq_empty  out  1  queue holds no entries.
- dispatch_rd  in  1  pop request from dispatch; may be asserted while empty.
- jump_branch_add  in  32  redirect target.
- jump_branch_valid  in  1  redirect/flush request.

## Operation
- State:
  - fetch_pc (32)
  - queue storage DEPTH×{pc, icode}
  - rd_ptr/wr_ptr (log2 DEPTH)
  - count (log2 DEPTH + 1)
  - inflight bit plus inflight_pc (32)
- Issue rule: imem_rd_en = ~rst & ~jump_branch_valid & (count + inflight < DEPTH); imem_addr = fetch_pc.
- On issue:
  - fetch_pc += 4, modulo 2^32; wrap-around is silent.
  - inflight ← 1; inflight_pc ← fetch_pc.
  - Without issue, inflight ← 0.
- Response: the cycle after an issue, {inflight_pc, imem_rdata} is written at wr_ptr; wr_ptr++ and count++. Space is guaranteed by the issue rule, so a write never overflows.
- Pop: pop = dispatch_rd & ~ifq_empty. Pop advances rd_ptr and decrements count. dispatch_rd while empty is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count, including DEPTH.
- Flush (jump_branch_valid = 1), next edge:
  - count ← 0 and rd_ptr = wr_ptr ← 0.
  - fetch_pc ← jump_branch_add.
  - The response arriving this cycle is dropped, as is the one arriving next cycle, because no issue happens during the flush cycle (inflight ← 0).
  - Flush has priority over a simultaneous pop and a simultaneous push.
- Back-to-back flushes: the last target wins; no instruction is queued between them.
- Head outputs:
  - ifq_icode/ifq_pc = entry[rd_ptr] when count > 0.
  - ifq_icode/ifq_pc are forced to 32'h0000_0013 (NOP) and 32'h0 when empty.
- ifq_empty = (count == 0), decoded from registered state only. It has no combinational path from any input.

## Timing
- Reset values:
  - fetch_pc = RESET_PC; count = 0; inflight = 0.
  - ifq_empty = 1; ifq_icode = NOP; ifq_pc = 0.
  - imem_rd_en = 0 while rst is high.
- First fetch: imem_rd_en = 1 with imem_addr = RESET_PC in the first cycle after rst deasserts (cycle 0). Data arrives in cycle 1; the head is valid (ifq_empty = 0) in cycle 2.
- Throughput: one instruction per cycle when dispatch pops every cycle.
- Redirect latency:
  - jump_branch_valid in cycle T.
  - Cycle T+1: ifq_empty = 1; imem_addr = target.
  - Cycle T+3: target instruction at head.
- Reset mid-operation: all state returns to reset values on that edge, and in-flight data is discarded.

## Structure
- Shared package ifq_pkg:
  - typedef ifq_entry_t {logic [31:0] pc; logic [31:0] icode;}
  - localparam NOP_ICODE = 32'h0000_0013
  - localparam PC_STEP = 4
- Sub-module ifq_buffer: parameterised circular buffer of ifq_entry_t.
  - Ports: clk, rst, flush, push, push_data, pop, head, count.
  - Holds no fetch logic, so it can be reused for other dispatch-side queues.
- Top: fetch PC, issue rule, inflight tracking, head output muxing.

## Test plan
- Reset with RESET_PC = 0x100 → imem_addr sequence 0x100, 0x104, 0x108, 0x10C; ifq_empty falls in cycle 2; ifq_pc = 0x100.
- dispatch_rd held 0 → exactly DEPTH requests issued, then imem_rd_en = 0 with count = DEPTH. One pop → exactly one new request on the next cycle.
- dispatch_rd = 1 continuously → one pop per cycle, count stable, ifq_pc incrementing by 4 with no bubbles.
- jump_branch_valid = 1, target 0x2000, with queue full and a read in flight → next cycle ifq_empty = 1 and imem_addr = 0x2000. The stale imem_rdata is never visible at the head; ifq_pc = 0x2000 in T+3.
- jump_branch_valid and dispatch_rd in the same cycle, plus flushes in consecutive cycles (0x40 then 0x80) → only the 0x80 stream appears, and no pointer corruption follows.
- fetch_pc = 0xFFFF_FFFC → the next address is 0x0000_0000. dispatch_rd while empty → count stays 0. rst asserted mid-stream → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/ifq_pkg.sv
// ---------------------------------------------------------------------------
// ifq_pkg
//   Shared types and constants for the instruction fetch queue and any other
//   dispatch-side queue that carries {pc, icode} pairs.
//     ifq_entry_t : one queued instruction (pc + instruction word)
//     NOP_ICODE   : instruction word presented to dispatch when the queue is empty
//     PC_STEP     : byte distance between sequential instruction fetches
// ---------------------------------------------------------------------------
package ifq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] icode;
    } ifq_entry_t;

    localparam logic [31:0] NOP_ICODE = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/ifq_buffer.sv
// ---------------------------------------------------------------------------
// ifq_buffer
//   Circular buffer of ifq_entry_t with show-ahead head output. It holds no
//   fetch logic so it can serve any dispatch-side queue.
//   Ports:
//     clk       : clock, all updates on the rising edge
//     rst       : synchronous active-high reset (pointers and count only)
//     flush     : empty the buffer on the next edge; beats push and pop
//     push      : write push_data at the tail
//     push_data : entry to write
//     pop       : advance the head; ignored while empty
//     head      : entry at the head (undefined contents while count == 0)
//     count     : number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module ifq_buffer
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  ifq_entry_t               push_data,
    input  logic                     pop,
    output ifq_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    ifq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop, do_push;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        // A push into a full buffer is only accepted when a pop frees a slot
        // in the same cycle, so a misbehaving producer cannot corrupt it.
        do_push  = push & ((count_q != FULL) | do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; it needs no reset because count gates its use.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifq_fetch.sv
// ---------------------------------------------------------------------------
// ifq_fetch
//   Instruction fetch queue in front of dispatch. Owns the fetch PC, issues
//   sequential word reads to a 1-cycle registered instruction memory, buffers
//   the returned {pc, icode} pairs and presents the head show-ahead. A
//   redirect flushes the queue, drops any in-flight read and restarts fetch
//   at the target.
//   Ports:
//     clk               : clock
//     rst               : synchronous active-high reset
//     imem_rd_en        : read request this cycle
//     imem_addr         : word-aligned byte address of the request
//     imem_rdata        : instruction word, valid the cycle after a request
//     ifq_icode         : head instruction (NOP when empty)
//     ifq_pc            : head PC (0 when empty)
//     ifq_empty         : queue holds no entries (registered state only)
//     dispatch_rd       : pop request; ignored while empty
//     jump_branch_add   : redirect target
//     jump_branch_valid : redirect / flush request
// ---------------------------------------------------------------------------
module ifq_fetch
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifq_icode,
    output logic [31:0] ifq_pc,
    output logic        ifq_empty,
    input  logic        dispatch_rd,
    input  logic [31:0] jump_branch_add,
    input  logic        jump_branch_valid
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          pop;
    ifq_entry_t    push_data;
    ifq_entry_t    head;

    always_comb begin
        // Reserve a slot for every outstanding read so a response can always
        // be written without checking for space.
        occupancy       = {1'b0, count} + {{CW{1'b0}}, inflight_q};
        issue           = ~rst & ~jump_branch_valid & (occupancy < DEPTH_C);
        pop             = dispatch_rd & (count != '0);
        push_data.pc    = inflight_pc_q;
        push_data.icode = imem_rdata;

        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (jump_branch_valid) begin
            fetch_pc_d = jump_branch_add;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
    end

    // The response landing during a redirect cycle is dropped by the
    // buffer's flush precedence; the redirect also suppresses issue, so
    // nothing arrives in the cycle after it either.
    ifq_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_branch_valid),
        .push      (inflight_q),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign imem_rd_en = issue;
    assign imem_addr  = fetch_pc_q;
    assign ifq_empty  = (count == '0);
    assign ifq_icode  = ifq_empty ? NOP_ICODE : head.icode;
    assign ifq_pc     = ifq_empty ? 32'h0     : head.pc;

endmodule

// File: tb/tb_ifq_fetch.sv
module tb_ifq_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ifq_icode;
    logic [31:0] ifq_pc;
    logic        ifq_empty;
    logic        dispatch_rd;
    logic [31:0] jump_branch_add;
    logic        jump_branch_valid;

    int n_cmp = 0;
    int n_err = 0;

    ifq_fetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_rd_en        (imem_rd_en),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .ifq_icode         (ifq_icode),
        .ifq_pc            (ifq_pc),
        .ifq_empty         (ifq_empty),
        .dispatch_rd       (dispatch_rd),
        .jump_branch_add   (jump_branch_add),
        .jump_branch_valid (jump_branch_valid)
    );

    always #5 clk = ~clk;

    // Registered instruction memory: word at address A is ~A.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= ~imem_addr;
    end

    task automatic test_reset_and_fill();
        int issued;
        logic [31:0] exp_addr;
        rst = 1'b1; dispatch_rd = 1'b0; jump_branch_valid = 1'b0; jump_branch_add = 32'h0;
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en got %0h want 0", imem_rd_en); end
            n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0h want 1", ifq_empty); end
            n_cmp++; if (ifq_icode !== 32'h13) begin n_err++; $display("FAIL rst_icode got %h want 00000013", ifq_icode); end
            n_cmp++; if (ifq_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 00000000", ifq_pc); end
        end
        issued = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            if (imem_rd_en === 1'b1) issued++;
            n_cmp++; if (imem_rd_en !== (c < 4)) begin n_err++; $display("FAIL fill_rd_en c%0d got %0h want %0h", c, imem_rd_en, (c < 4)); end
            if (c < 4) begin
                exp_addr = 32'h100 + 32'(4 * c);
                n_cmp++; if (imem_addr !== exp_addr) begin n_err++; $display("FAIL fill_addr c%0d got %h want %h", c, imem_addr, exp_addr); end
            end
            n_cmp++; if (ifq_empty !== (c < 2)) begin n_err++; $display("FAIL fill_empty c%0d got %0h want %0h", c, ifq_empty, (c < 2)); end
            if (c >= 2) begin
                n_cmp++; if (ifq_pc !== 32'h100) begin n_err++; $display("FAIL fill_pc c%0d got %h want 00000100", c, ifq_pc); end
                n_cmp++; if (ifq_icode !== ~32'h100) begin n_err++; $display("FAIL fill_icode c%0d got %h want %h", c, ifq_icode, ~32'h100); end
            end
        end
        n_cmp++; if (issued !== 4) begin n_err++; $display("FAIL fill_issue_count got %0d want 4", issued); end

        // One pop from a full queue frees exactly one slot.
        @(negedge clk); dispatch_rd = 1'b1; #1;
        n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL pop1_rd_en got %0h want 0", imem_rd_en); end
        @(negedge clk); dispatch_rd = 1'b0; #1;
        n_cmp++; if (imem_rd_en !== 1'b1) begin n_err++; $display("FAIL pop1_refill_rd_en got %0h want 1", imem_rd_en); end
        n_cmp++; if (imem_addr !== 32'h110) begin n_err++; $display("FAIL pop1_refill_addr got %h want 00000110", imem_addr); end
        n_cmp++; if (ifq_pc !== 32'h104) begin n_err++; $display("FAIL pop1_head_pc got %h want 00000104", ifq_pc); end
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL pop1_after_rd_en got %0h want 0", imem_rd_en); end
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); dispatch_rd = 1'b1; #1;
            exp_pc = 32'h104 + 32'(4 * k);
            n_cmp++; if (ifq_empty !== 1'b0) begin n_err++; $display("FAIL stream_empty k%0d got %0h want 0", k, ifq_empty); end
            n_cmp++; if (ifq_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc k%0d got %h want %h", k, ifq_pc, exp_pc); end
            n_cmp++; if (ifq_icode !== ~exp_pc) begin n_err++; $display("FAIL stream_icode k%0d got %h want %h", k, ifq_icode, ~exp_pc); end
            n_cmp++; if (imem_rd_en !== (k != 0)) begin n_err++; $display("FAIL stream_rd_en k%0d got %0h want %0h", k, imem_rd_en, (k != 0)); end
            if (k != 0) begin
                exp_addr = 32'h114 + 32'(4 * (k - 1));
                n_cmp++; if (imem_addr !== exp_addr) begin n_err++; $display("FAIL stream_addr k%0d got %h want %h", k, imem_addr, exp_addr); end
            end
        end
    endtask

    task automatic test_flush_full();
        // Stop popping: one more read goes out and is in flight at the redirect.
        @(negedge clk); dispatch_rd = 1'b0; #1;
        n_cmp++; if (imem_rd_en !== 1'b1) begin n_err++; $display("FAIL ff_pre_rd_en got %0h want 1", imem_rd_en); end
        n_cmp++; if (imem_addr !== 32'h138) begin n_err++; $display("FAIL ff_pre_addr got %h want 00000138", imem_addr); end
        @(negedge clk); jump_branch_valid = 1'b1; jump_branch_add = 32'h2000; #1;
        n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL ff_T_rd_en got %0h want 0", imem_rd_en); end
        n_cmp++; if (ifq_empty !== 1'b0) begin n_err++; $display("FAIL ff_T_empty got %0h want 0", ifq_empty); end
        @(negedge clk); jump_branch_valid = 1'b0; #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL ff_T1_empty got %0h want 1", ifq_empty); end
        n_cmp++; if (ifq_icode !== 32'h13) begin n_err++; $display("FAIL ff_T1_icode got %h want 00000013", ifq_icode); end
        n_cmp++; if (ifq_pc !== 32'h0) begin n_err++; $display("FAIL ff_T1_pc got %h want 00000000", ifq_pc); end
        n_cmp++; if (imem_rd_en !== 1'b1) begin n_err++; $display("FAIL ff_T1_rd_en got %0h want 1", imem_rd_en); end
        n_cmp++; if (imem_addr !== 32'h2000) begin n_err++; $display("FAIL ff_T1_addr got %h want 00002000", imem_addr); end
        @(negedge clk); #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL ff_T2_empty got %0h want 1", ifq_empty); end
        n_cmp++; if (imem_addr !== 32'h2004) begin n_err++; $display("FAIL ff_T2_addr got %h want 00002004", imem_addr); end
        @(negedge clk); #1;
        n_cmp++; if (ifq_empty !== 1'b0) begin n_err++; $display("FAIL ff_T3_empty got %0h want 0", ifq_empty); end
        n_cmp++; if (ifq_pc !== 32'h2000) begin n_err++; $display("FAIL ff_T3_pc got %h want 00002000", ifq_pc); end
        n_cmp++; if (ifq_icode !== ~32'h2000) begin n_err++; $display("FAIL ff_T3_icode got %h want %h", ifq_icode, ~32'h2000); end
    endtask

    task automatic test_flush_b2b();
        logic [31:0] exp_pc;
        @(negedge clk); dispatch_rd = 1'b1; jump_branch_valid = 1'b1; jump_branch_add = 32'h40; #1;
        n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL b2b_A_rd_en got %0h want 0", imem_rd_en); end
        n_cmp++; if (ifq_pc !== 32'h2000) begin n_err++; $display("FAIL b2b_A_pc got %h want 00002000", ifq_pc); end
        @(negedge clk); jump_branch_add = 32'h80; #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL b2b_B_empty got %0h want 1", ifq_empty); end
        n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL b2b_B_rd_en got %0h want 0", imem_rd_en); end
        @(negedge clk); jump_branch_valid = 1'b0; #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL b2b_C_empty got %0h want 1", ifq_empty); end
        n_cmp++; if (imem_addr !== 32'h80) begin n_err++; $display("FAIL b2b_C_addr got %h want 00000080", imem_addr); end
        n_cmp++; if (imem_rd_en !== 1'b1) begin n_err++; $display("FAIL b2b_C_rd_en got %0h want 1", imem_rd_en); end
        @(negedge clk); #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL b2b_D_empty got %0h want 1", ifq_empty); end
        n_cmp++; if (imem_addr !== 32'h84) begin n_err++; $display("FAIL b2b_D_addr got %h want 00000084", imem_addr); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            exp_pc = 32'h80 + 32'(4 * k);
            n_cmp++; if (ifq_empty !== 1'b0) begin n_err++; $display("FAIL b2b_stream_empty k%0d got %0h want 0", k, ifq_empty); end
            n_cmp++; if (ifq_pc !== exp_pc) begin n_err++; $display("FAIL b2b_stream_pc k%0d got %h want %h", k, ifq_pc, exp_pc); end
            n_cmp++; if (ifq_icode !== ~exp_pc) begin n_err++; $display("FAIL b2b_stream_icode k%0d got %h want %h", k, ifq_icode, ~exp_pc); end
        end
    endtask

    task automatic test_wrap_empty_pop();
        // dispatch_rd stays high throughout, including while the queue is empty.
        @(negedge clk); jump_branch_valid = 1'b1; jump_branch_add = 32'hFFFF_FFFC; #1;
        @(negedge clk); jump_branch_valid = 1'b0; #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL wrap_T1_empty got %0h want 1", ifq_empty); end
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_T1_addr got %h want fffffffc", imem_addr); end
        @(negedge clk); #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL wrap_T2_empty_pop got %0h want 1", ifq_empty); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_T2_addr got %h want 00000000", imem_addr); end
        @(negedge clk); #1;
        n_cmp++; if (ifq_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_T3_pc got %h want fffffffc", ifq_pc); end
        n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL wrap_T3_addr got %h want 00000004", imem_addr); end
        @(negedge clk); #1;
        n_cmp++; if (ifq_pc !== 32'h0) begin n_err++; $display("FAIL wrap_T4_pc got %h want 00000000", ifq_pc); end
        n_cmp++; if (ifq_icode !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_T4_icode got %h want ffffffff", ifq_icode); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL rmid_R_rd_en got %0h want 0", imem_rd_en); end
        @(negedge clk); rst = 1'b0; dispatch_rd = 1'b0; #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL rmid_R1_empty got %0h want 1", ifq_empty); end
        n_cmp++; if (ifq_icode !== 32'h13) begin n_err++; $display("FAIL rmid_R1_icode got %h want 00000013", ifq_icode); end
        n_cmp++; if (ifq_pc !== 32'h0) begin n_err++; $display("FAIL rmid_R1_pc got %h want 00000000", ifq_pc); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL rmid_R1_addr got %h want 00000100", imem_addr); end
        n_cmp++; if (imem_rd_en !== 1'b1) begin n_err++; $display("FAIL rmid_R1_rd_en got %0h want 1", imem_rd_en); end
        @(negedge clk); #1;
        n_cmp++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL rmid_R2_empty got %0h want 1", ifq_empty); end
        @(negedge clk); #1;
        n_cmp++; if (ifq_pc !== 32'h100) begin n_err++; $display("FAIL rmid_R3_pc got %h want 00000100", ifq_pc); end
        n_cmp++; if (ifq_icode !== ~32'h100) begin n_err++; $display("FAIL rmid_R3_icode got %h want %h", ifq_icode, ~32'h100); end
    endtask

    initial begin
        test_reset_and_fill();
        test_stream();
        test_flush_full();
        test_flush_b2b();
        test_wrap_empty_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
